agc_period_ctrl: RTL

- Common AGC measurement sequencer, one instance shared by all channels.
- Issues the per-period accumulator reset pulse (agc_tick_o) and the accumulate window (agc_ce_o) to every per-channel AGC core.
- Snapshots every channel's square and probit accumulators once they settle, then presents the snapshot to the register core with a valid/ack handshake.
- Sits between the AGC cores (upstream, producing accumulators) and the register/scale-calculation logic (downstream).

---
 rtl/agc_period_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/agc_period_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : agc_period_ctrl
// Purpose : Common AGC measurement sequencer shared by all channels. Issues
//           the period-start accumulator reset (agc_tick_o) and the
//           accumulate window (agc_ce_o) to every per-channel AGC core. Once
//           the accumulators have settled, it takes a coherent snapshot of
//           all channels and offers it downstream with a valid/ack handshake.
//
// Ports   :
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   enable_i       measurement enable from the register core
//   agc_tick_o     one-cycle accumulator reset / period start
//   agc_ce_o       accumulate enable (2^PERIOD_LOG2 cycles per period)
//   sq_accum_i     square accumulators, channel k at [SQ_BITS*k +: SQ_BITS]
//   gt_accum_i     greater-than probit accumulators
//   lt_accum_i     less-than probit accumulators
//   sq_o/gt_o/lt_o captured snapshot
//   valid_o        snapshot valid and not yet consumed
//   ack_i          consumer has read the snapshot
//   overrun_o      sticky: a capture was dropped while valid_o was high
//   clr_overrun_i  clears overrun_o
//
// Revision: 1.0 - initial release
// ============================================================================
module agc_period_ctrl #(
  parameter int NCH         = 8,
  parameter int SQ_BITS     = 25,
  parameter int PR_BITS     = 21,
  parameter int PERIOD_LOG2 = 17,
  parameter int SETTLE_CLKS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     enable_i,
  output logic                     agc_tick_o,
  output logic                     agc_ce_o,
  input  logic [NCH*SQ_BITS-1:0]   sq_accum_i,
  input  logic [NCH*PR_BITS-1:0]   gt_accum_i,
  input  logic [NCH*PR_BITS-1:0]   lt_accum_i,
  output logic [NCH*SQ_BITS-1:0]   sq_o,
  output logic [NCH*PR_BITS-1:0]   gt_o,
  output logic [NCH*PR_BITS-1:0]   lt_o,
  output logic                     valid_o,
  input  logic                     ack_i,
  output logic                     overrun_o,
  input  logic                     clr_overrun_i
);

  localparam int CW = PERIOD_LOG2 + 1;

  // Terminal counts; the counter restarts from zero on entry to RUN/SETTLE.
  localparam logic [CW-1:0] RUN_LAST    = {1'b0, {PERIOD_LOG2{1'b1}}};
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TICK    = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_q, ce_q;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            load, drop;
  logic            eff_full;

  logic [NCH*SQ_BITS-1:0] sq_q;
  logic [NCH*PR_BITS-1:0] gt_q;
  logic [NCH*PR_BITS-1:0] lt_q;

  // An ack arriving on the capture cycle frees the slot for the new set.
  assign eff_full = valid_q & ~ack_i;

  // --------------------------------------------------------------------------
  // Next-state, counter and handshake decisions
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    drop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_TICK;
      end
      ST_TICK: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Back-to-back periods: the next tick follows capture directly.
        state_d = ST_TICK;
        load    = ~eff_full;
        drop    = eff_full;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable aborts the period from any state, including capture.
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      load    = 1'b0;
      drop    = 1'b0;
    end

    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (ack_i) begin
      valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear wins.
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State register and registered Moore outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      ce_q      <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // Decoded from the next state so tick/ce are true flop outputs that
      // line up with the state they belong to.
      tick_q    <= (state_d == ST_TICK);
      ce_q      <= (state_d == ST_RUN);
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Snapshot registers: all channels load together in the capture cycle
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sq_q <= '0;
      gt_q <= '0;
      lt_q <= '0;
    end else if (load) begin
      sq_q <= sq_accum_i;
      gt_q <= gt_accum_i;
      lt_q <= lt_accum_i;
    end
  end

  assign agc_tick_o = tick_q;
  assign agc_ce_o   = ce_q;
  assign valid_o    = valid_q;
  assign overrun_o  = overrun_q;
  assign sq_o       = sq_q;
  assign gt_o       = gt_q;
  assign lt_o       = lt_q;

endmodule
`default_nettype wire
